address_sequencer: RTL and testbench

ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

---
 rtl/address_sequencer_pkg.sv | 56 +++++
 rtl/address_sequencer_addr_decode.sv | 56 +++++
 rtl/address_sequencer.sv | 164 ++++++++++++++++
 tb/tb_address_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/address_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : address_sequencer_pkg
// Brief   : Shared encodings for the address sequencer and its decoder.
// Revision: 1.0
// ============================================================================
package address_sequencer_pkg;

    typedef enum logic [2:0] {
        R11 = 3'd0,
        R12 = 3'd1,
        R13 = 3'd2,
        R14 = 3'd3,
        R15 = 3'd4
    } row_widths;

    typedef enum logic [1:0] {
        C9  = 2'd0,
        C10 = 2'd1,
        C11 = 2'd2
    } col_widths;

    localparam logic MAP_RANK_BANK_ROW_COL = 1'b0;
    localparam logic MAP_RANK_ROW_BANK_COL = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } seq_state_t;

    function automatic int unsigned row_bits(input row_widths w);
        int unsigned n;
        case (w)
            R11:     n = 11;
            R12:     n = 12;
            R13:     n = 13;
            R14:     n = 14;
            R15:     n = 15;
            default: n = 11;
        endcase
        return n;
    endfunction

    function automatic int unsigned col_bits(input col_widths w);
        int unsigned n;
        case (w)
            C9:      n = 9;
            C10:     n = 10;
            C11:     n = 11;
            default: n = 9;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/address_sequencer_addr_decode.sv
`default_nettype none
// ============================================================================
// Module  : addr_decode
// Brief   : Combinational byte address to {rank, bank, row, col} mapping.
// Revision: 1.0
// ============================================================================
module addr_decode
    import address_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int CS_WIDTH    = 2,
    parameter int OFFSET_BITS = 2
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  row_widths             i_r_width,
    input  col_widths             i_c_width,
    input  logic                  i_map_mode,
    output logic [CS_WIDTH-1:0]   o_rank,
    output logic [2:0]            o_bank,
    output logic [15:0]           o_row,
    output logic [11:0]           o_col
);

    localparam int                    RANK_BITS = $clog2(CS_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] C_ONE     = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] w_unit;
    logic [ADDR_WIDTH-1:0] w_upper;
    logic [ADDR_WIDTH-1:0] w_row_raw;
    logic [ADDR_WIDTH-1:0] w_bank_raw;
    logic [ADDR_WIDTH-1:0] w_rank_idx;
    int unsigned           w_wc;
    int unsigned           w_wr;

    always_comb begin
        w_wc    = col_bits(i_c_width);
        w_wr    = row_bits(i_r_width);
        w_unit  = i_addr >> OFFSET_BITS;
        w_upper = w_unit >> w_wc;
        // Field order above the column depends on the interleave mode.
        if (i_map_mode == MAP_RANK_BANK_ROW_COL) begin
            w_row_raw  = w_upper;
            w_bank_raw = w_upper >> w_wr;
        end else begin
            w_bank_raw = w_upper;
            w_row_raw  = w_upper >> 3;
        end
        w_rank_idx = (w_upper >> (w_wr + 3)) & ((C_ONE << RANK_BITS) - C_ONE);
        o_col      = 12'(w_unit & ((C_ONE << w_wc) - C_ONE));
        o_row      = 16'(w_row_raw & ((C_ONE << w_wr) - C_ONE));
        o_bank     = 3'(w_bank_raw);
        o_rank     = CS_WIDTH'(1) << w_rank_idx;
    end

endmodule
`default_nettype wire

// File: rtl/address_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : address_sequencer
// Brief   : Expands INCR burst requests into one DRAM command per beat.
// Revision: 1.0
// ============================================================================
module address_sequencer
    import address_sequencer_pkg::*;
#(
    parameter int C_NASTI_ADDR_WIDTH = 32,
    parameter int C_NASTI_DATA_WIDTH = 256,
    parameter int C_NASTI_ID_WIDTH   = 4,
    parameter int C_DFI_CS_WIDTH     = 2,
    parameter int C_DFI_DATA_WIDTH   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  row_widths                     r_width,
    input  col_widths                     c_width,
    input  logic                          map_mode,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [C_NASTI_ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]                    req_len,
    input  logic [C_NASTI_ID_WIDTH-1:0]   req_id,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [C_DFI_CS_WIDTH-1:0]     cmd_rank,
    output logic [2:0]                    cmd_bank,
    output logic [15:0]                   cmd_row,
    output logic [11:0]                   cmd_col,
    output logic [C_NASTI_ID_WIDTH-1:0]   cmd_id,
    output logic                          cmd_last,
    output logic                          cmd_new_row
);

    localparam int AW          = C_NASTI_ADDR_WIDTH;
    localparam int OFFSET_BITS = $clog2(C_DFI_DATA_WIDTH / 16);
    localparam int STEP_BYTES  = C_NASTI_DATA_WIDTH / 8;

    localparam logic [AW-1:0] C_STEP       = AW'(STEP_BYTES);
    localparam logic [AW-1:0] C_ALIGN_MASK = ~AW'(STEP_BYTES - 1);

    seq_state_t              r_state;
    seq_state_t              w_state_next;
    logic [AW-1:0]           r_addr;
    row_widths               r_r_width;
    col_widths               r_c_width;
    logic                    r_map_mode;
    logic [7:0]              r_beat_cnt;

    logic                    w_fire;
    logic                    w_accept;
    logic                    w_row_change;
    logic [AW-1:0]           w_next_addr;
    row_widths               w_dec_r_width;
    col_widths               w_dec_c_width;
    logic                    w_dec_mode;
    logic [C_DFI_CS_WIDTH-1:0] w_dec_rank;
    logic [2:0]              w_dec_bank;
    logic [15:0]             w_dec_row;
    logic [11:0]             w_dec_col;

    always_comb begin
        w_fire    = cmd_valid && cmd_ready;
        req_ready = (r_state == ST_IDLE) || (w_fire && cmd_last);
        w_accept  = req_valid && req_ready;
    end

    // The decoder always sees the address/config of the beat about to be loaded.
    always_comb begin
        if (w_accept) begin
            w_next_addr   = req_addr & C_ALIGN_MASK;
            w_dec_r_width = r_width;
            w_dec_c_width = c_width;
            w_dec_mode    = map_mode;
        end else begin
            w_next_addr   = r_addr + C_STEP;
            w_dec_r_width = r_r_width;
            w_dec_c_width = r_c_width;
            w_dec_mode    = r_map_mode;
        end
    end

    addr_decode #(
        .ADDR_WIDTH  (AW),
        .CS_WIDTH    (C_DFI_CS_WIDTH),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_addr_decode (
        .i_addr     (w_next_addr),
        .i_r_width  (w_dec_r_width),
        .i_c_width  (w_dec_c_width),
        .i_map_mode (w_dec_mode),
        .o_rank     (w_dec_rank),
        .o_bank     (w_dec_bank),
        .o_row      (w_dec_row),
        .o_col      (w_dec_col)
    );

    assign w_row_change = {w_dec_rank, w_dec_bank, w_dec_row} != {cmd_rank, cmd_bank, cmd_row};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_BURST;
            ST_BURST: if (w_fire && cmd_last && !w_accept) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_r_width   <= R11;
            r_c_width   <= C9;
            r_map_mode  <= 1'b0;
            r_beat_cnt  <= 8'd0;
            cmd_valid   <= 1'b0;
            cmd_last    <= 1'b0;
            cmd_new_row <= 1'b0;
            cmd_rank    <= '0;
            cmd_bank    <= 3'd0;
            cmd_row     <= 16'd0;
            cmd_col     <= 12'd0;
            cmd_id      <= '0;
        end else if (w_accept) begin
            r_addr      <= w_next_addr;
            r_r_width   <= r_width;
            r_c_width   <= c_width;
            r_map_mode  <= map_mode;
            r_beat_cnt  <= req_len;
            cmd_valid   <= 1'b1;
            cmd_last    <= (req_len == 8'd0);
            cmd_new_row <= 1'b0;
            cmd_rank    <= w_dec_rank;
            cmd_bank    <= w_dec_bank;
            cmd_row     <= w_dec_row;
            cmd_col     <= w_dec_col;
            cmd_id      <= req_id;
        end else if (w_fire) begin
            if (cmd_last) begin
                cmd_valid   <= 1'b0;
                cmd_last    <= 1'b0;
                cmd_new_row <= 1'b0;
            end else begin
                r_addr      <= w_next_addr;
                r_beat_cnt  <= r_beat_cnt - 8'd1;
                cmd_last    <= (r_beat_cnt == 8'd1);
                cmd_new_row <= w_row_change;
                cmd_rank    <= w_dec_rank;
                cmd_bank    <= w_dec_bank;
                cmd_row     <= w_dec_row;
                cmd_col     <= w_dec_col;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_address_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_address_sequencer
// Brief   : Self-checking bench: vector table plus scoreboard of expected beats.
// Revision: 1.0
// ============================================================================
module tb_address_sequencer;
    import address_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    row_widths   r_width;
    col_widths   c_width;
    logic        map_mode;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [3:0]  req_id;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_rank;
    logic [2:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [11:0] cmd_col;
    logic [3:0]  cmd_id;
    logic        cmd_last;
    logic        cmd_new_row;

    address_sequencer #(
        .C_NASTI_ADDR_WIDTH (32),
        .C_NASTI_DATA_WIDTH (256),
        .C_NASTI_ID_WIDTH   (4),
        .C_DFI_CS_WIDTH     (2),
        .C_DFI_DATA_WIDTH   (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .r_width     (r_width),
        .c_width     (c_width),
        .map_mode    (map_mode),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_id      (req_id),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rank    (cmd_rank),
        .cmd_bank    (cmd_bank),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .cmd_id      (cmd_id),
        .cmd_last    (cmd_last),
        .cmd_new_row (cmd_new_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rank;
        logic [2:0]  bank;
        logic [15:0] row;
        logic [11:0] col;
        logic [3:0]  id;
        logic        last;
        logic        new_row;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        row_widths   rw;
        col_widths   cw;
        logic        mode;
        logic [32:0] exp_first;
        logic [33:0] exp_last;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    beat_t       exp_q[$];
    logic        in_burst = 1'b0;
    logic [32:0] dut_first;
    logic [33:0] dut_last;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] fb(input logic [1:0] rk, input logic [2:0] bk,
                                       input logic [15:0] rw, input logic [11:0] cl);
        return {rk, bk, rw, cl};
    endfunction

    // Arithmetic (divide/modulo) reference for the address interleave.
    function automatic beat_t decode_model(input logic [31:0] a, input int wr, input int wc,
                                           input logic mode);
        longint unsigned u;
        beat_t           b;
        u = 64'(a) / 4;
        b.col = 12'(u % (64'd1 << wc));
        u = u / (64'd1 << wc);
        if (!mode) begin
            b.row  = 16'(u % (64'd1 << wr));
            u      = u / (64'd1 << wr);
            b.bank = 3'(u % 8);
            u      = u / 8;
        end else begin
            b.bank = 3'(u % 8);
            u      = u / 8;
            b.row  = 16'(u % (64'd1 << wr));
            u      = u / (64'd1 << wr);
        end
        b.rank    = ((u % 2) != 0) ? 2'b10 : 2'b01;
        b.id      = 4'd0;
        b.last    = 1'b0;
        b.new_row = 1'b0;
        return b;
    endfunction

    task automatic push_burst(input logic [31:0] a0, input logic [7:0] len, input logic [3:0] id,
                              input row_widths rw, input col_widths cw, input logic mode);
        logic [31:0] a;
        beat_t       b;
        beat_t       p;
        a = a0 & 32'hFFFF_FFE0;
        for (int i = 0; i <= int'(len); i++) begin
            b         = decode_model(a, 11 + int'(rw), 9 + int'(cw), mode);
            b.id      = id;
            b.last    = (i == int'(len));
            b.new_row = (i != 0) && ({b.rank, b.bank, b.row} != {p.rank, p.bank, p.row});
            exp_q.push_back(b);
            p = b;
            a = a + 32'd32;
        end
    endtask

    // Scoreboard: every displayed beat (stalled or not) must match the queue head.
    always @(negedge clk) begin
        if (!rst && cmd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", {cmd_rank, cmd_bank, cmd_row, cmd_col}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("beat", {cmd_rank, cmd_bank, cmd_row, cmd_col, cmd_id, cmd_last, cmd_new_row},
                    {exp_q[0].rank, exp_q[0].bank, exp_q[0].row, exp_q[0].col,
                     exp_q[0].id, exp_q[0].last, exp_q[0].new_row});
                if (cmd_ready) begin
                    if (!in_burst) dut_first = {cmd_rank, cmd_bank, cmd_row, cmd_col};
                    in_burst = 1'b1;
                    if (cmd_last) begin
                        dut_last = {cmd_rank, cmd_bank, cmd_row, cmd_col, cmd_new_row};
                        in_burst = 1'b0;
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_req(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                            input row_widths rw, input col_widths cw, input logic mode);
        int t;
        @(posedge clk); #1;
        push_burst(a, len, id, rw, cw, mode);
        req_addr  = a;
        req_len   = len;
        req_id    = id;
        r_width   = rw;
        c_width   = cw;
        map_mode  = mode;
        req_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("req_accept", req_ready, 1);
        if (cmd_valid) chk("accept_on_last", cmd_last, 1);
        @(posedge clk); #1;
        // Scramble config after accept: the burst must keep the sampled values.
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_len   = 8'hFF;
        r_width   = R11;
        c_width   = C11;
        map_mode  = ~mode;
        @(negedge clk);
        chk("first_beat_latency", cmd_valid, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || cmd_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0000, 8'd3, R14, C10, 1'b0, fb(2'b01, 3'd0, 16'd0, 12'd0),
                    {fb(2'b01, 3'd0, 16'd0, 12'd24), 1'b0}};
        vecs[1] = '{32'h0000_0FE0, 8'd1, R14, C10, 1'b0, fb(2'b01, 3'd0, 16'd0, 12'd1016),
                    {fb(2'b01, 3'd0, 16'd1, 12'd0), 1'b1}};
        vecs[2] = '{32'h2000_0000, 8'd0, R14, C10, 1'b0, fb(2'b10, 3'd0, 16'd0, 12'd0),
                    {fb(2'b10, 3'd0, 16'd0, 12'd0), 1'b0}};
        vecs[3] = '{32'h0000_1000, 8'd0, R14, C10, 1'b1, fb(2'b01, 3'd1, 16'd0, 12'd0),
                    {fb(2'b01, 3'd1, 16'd0, 12'd0), 1'b0}};
        vecs[4] = '{32'h0000_001F, 8'd0, R11, C9, 1'b0, fb(2'b01, 3'd0, 16'd0, 12'd0),
                    {fb(2'b01, 3'd0, 16'd0, 12'd0), 1'b0}};
        vecs[5] = '{32'h0000_3FE0, 8'd2, R15, C11, 1'b0, fb(2'b01, 3'd0, 16'd1, 12'd2040),
                    {fb(2'b01, 3'd0, 16'd2, 12'd8), 1'b0}};
        vecs[6] = '{32'hFFFF_FFE0, 8'd1, R14, C10, 1'b0, fb(2'b10, 3'd7, 16'd16383, 12'd1016),
                    {fb(2'b01, 3'd0, 16'd0, 12'd0), 1'b1}};
        vecs[7] = '{32'h0000_3FE0, 8'd1, R12, C9, 1'b1, fb(2'b01, 3'd7, 16'd0, 12'd504),
                    {fb(2'b01, 3'd0, 16'd1, 12'd0), 1'b1}};

        rst       = 1'b1;
        r_width   = R11;
        c_width   = C9;
        map_mode  = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_len   = 8'd0;
        req_id    = 4'd0;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_valid", cmd_valid, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_flags", {cmd_last, cmd_new_row}, 0);
        chk("reset_fields", {cmd_rank, cmd_bank, cmd_row, cmd_col, cmd_id}, 0);

        for (int i = 0; i < 8; i++) begin
            dut_first = '1;
            dut_last  = '1;
            send_req(vecs[i].addr, vecs[i].len, 4'(i), vecs[i].rw, vecs[i].cw, vecs[i].mode);
            wait_idle();
            chk($sformatf("vec%0d_first", i), dut_first, vecs[i].exp_first);
            chk($sformatf("vec%0d_last", i), dut_last, vecs[i].exp_last);
        end

        // Backpressure: three stalled cycles mid-burst.
        send_req(32'h0000_0100, 8'd5, 4'd9, R13, C10, 1'b0);
        @(posedge clk); #1 cmd_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", cmd_valid, 1);
        end
        @(posedge clk); #1 cmd_ready = 1'b1;
        wait_idle();

        // Back-to-back: second request taken on the last beat of the first.
        send_req(32'h0000_0400, 8'd2, 4'd3, R14, C10, 1'b0);
        send_req(32'h0000_07E0, 8'd1, 4'd4, R12, C11, 1'b1);
        wait_idle();

        // Reset in the middle of an 8-beat burst.
        send_req(32'h0000_0000, 8'd7, 4'd5, R14, C10, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cmd_valid", cmd_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        exp_q.delete();
        in_burst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_stale", cmd_valid, 0);
        chk("rst_idle_ready", req_ready, 1);

        // Recovery after reset.
        dut_first = '1;
        send_req(32'h0000_2040, 8'd0, 4'd6, R14, C10, 1'b0);
        wait_idle();
        chk("recover_first", dut_first, fb(2'b01, 3'd0, 16'd2, 12'd16));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
